// File: rtl/nap_pkg.sv
// Package: nap_pkg
// Shared types and helpers for the nap countdown timer bank.
//   bcd_time_t      packed HH:MM:SS, six 4-bit BCD digits, h10 in the MSBs
//   cd_state_e      per-channel timer state
//   ZERO_TIME       00:00:00
//   bcd_time_valid  1 when every digit is legal and hours <= max_hour
//   bcd_time_dec    one-second BCD decrement with borrow (saturates at zero)
package nap_pkg;

  typedef struct packed {
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  typedef enum logic [1:0] {
    CD_IDLE,
    CD_RUN,
    CD_PAUSE,
    CD_EXPIRED
  } cd_state_e;

  localparam bcd_time_t ZERO_TIME = '0;

  function automatic logic bcd_time_valid(input bcd_time_t t, input int unsigned max_hour);
    logic        digits_ok;
    int unsigned hours;
    digits_ok = (t.h10 <= 4'd9) && (t.h1 <= 4'd9) &&
                (t.m10 <= 4'd5) && (t.m1 <= 4'd9) &&
                (t.s10 <= 4'd5) && (t.s1 <= 4'd9);
    hours = 32'(t.h10) * 32'd10 + 32'(t.h1);
    return digits_ok && (hours <= max_hour);
  endfunction

  function automatic bcd_time_t bcd_time_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    // Zero is a fixed point so a stray call can never wrap to 99:59:59.
    if (t != ZERO_TIME) begin
      if (r.s1 != 4'd0) r.s1 = r.s1 - 4'd1;
      else begin
        r.s1 = 4'd9;
        if (r.s10 != 4'd0) r.s10 = r.s10 - 4'd1;
        else begin
          r.s10 = 4'd5;
          if (r.m1 != 4'd0) r.m1 = r.m1 - 4'd1;
          else begin
            r.m1 = 4'd9;
            if (r.m10 != 4'd0) r.m10 = r.m10 - 4'd1;
            else begin
              r.m10 = 4'd5;
              if (r.h1 != 4'd0) r.h1 = r.h1 - 4'd1;
              else begin
                r.h1  = 4'd9;
                r.h10 = r.h10 - 4'd1;
              end
            end
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nap_countdown_channel.sv
// Module: nap_countdown_channel
// One BCD HH:MM:SS countdown timer: state machine, time register, snooze counter.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-low reset
//   tick       in   1 s strobe from the shared prescaler
//   load       in   latch load_time (if valid)
//   load_time  in   BCD time to load
//   start      in   run request
//   pause      in   pause request
//   clear      in   clear to 00:00:00 / IDLE
//   snooze     in   snooze request while expired
//   cur_time   out  current BCD time (registered)
//   running    out  1 while in RUN
//   expired    out  1 while in EXPIRED
//   complete   out  1-cycle pulse on reaching 00:00:00
//   load_err   out  1-cycle pulse after a load strobe with invalid BCD
module nap_countdown_channel
  import nap_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned MAX_HOUR   = 23
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      tick,
  input  logic      load,
  input  bcd_time_t load_time,
  input  logic      start,
  input  logic      pause,
  input  logic      clear,
  input  logic      snooze,
  output bcd_time_t cur_time,
  output logic      running,
  output logic      expired,
  output logic      complete,
  output logic      load_err
);

  localparam int unsigned CNT_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SNOOZE);

  localparam bcd_time_t SNOOZE_TIME = '{
    h10: 4'd0, h1: 4'd0,
    m10: 4'(SNOOZE_MIN / 10), m1: 4'(SNOOZE_MIN % 10),
    s10: 4'd0, s1: 4'd0
  };

  cd_state_e        state;
  logic [CNT_W-1:0] snooze_cnt;
  logic             load_ok;
  bcd_time_t        dec_time;

  assign load_ok  = bcd_time_valid(load_time, MAX_HOUR);
  assign dec_time = bcd_time_dec(cur_time);

  assign running = (state == CD_RUN);
  assign expired = (state == CD_EXPIRED);

  // The if/else-if chain is the command priority: clear > load > snooze >
  // pause > start > tick. A command that is not applicable in the current
  // state falls through, so only an accepted command swallows the tick.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous, so it lives inside the clocked block and all
    // state uses non-blocking assignments to avoid read/write ordering races.
    if (!reset) begin
      state      <= CD_IDLE;
      cur_time   <= ZERO_TIME;
      snooze_cnt <= '0;
      complete   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      complete <= 1'b0;
      // Flag a bad load even if clear wins the same edge.
      load_err <= load && !load_ok;

      if (clear) begin
        state      <= CD_IDLE;
        cur_time   <= ZERO_TIME;
        snooze_cnt <= '0;
      end else if (load) begin
        // An invalid load leaves the channel untouched and still costs the tick.
        if (load_ok) begin
          state      <= CD_IDLE;
          cur_time   <= load_time;
          snooze_cnt <= '0;
        end
      end else if (snooze && (state == CD_EXPIRED) && (snooze_cnt < CNT_MAX)) begin
        state      <= CD_RUN;
        cur_time   <= SNOOZE_TIME;
        snooze_cnt <= snooze_cnt + CNT_W'(1);
      end else if (pause && (state == CD_RUN)) begin
        state <= CD_PAUSE;
      end else if (start && ((state == CD_IDLE) || (state == CD_PAUSE)) &&
                   (cur_time != ZERO_TIME)) begin
        state <= CD_RUN;
      end else if (tick && (state == CD_RUN)) begin
        cur_time <= dec_time;
        if (dec_time == ZERO_TIME) begin
          state    <= CD_EXPIRED;
          complete <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nap_countdown_bank.sv
// Module: nap_countdown_bank
// Bank of CHANNELS independent BCD HH:MM:SS countdown timers sharing one
// 1 Hz prescaler, with one channel muxed out for the 7-segment display.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-low reset
//   load       in   [CHANNELS] per-channel load strobe
//   load_time  in   [24] BCD {h10,h1,m10,m1,s10,s1}
//   start      in   [CHANNELS] per-channel run request
//   pause      in   [CHANNELS] per-channel pause request
//   clear      in   [CHANNELS] per-channel clear
//   snooze     in   [CHANNELS] per-channel snooze request
//   sel        in   [SEL_W] channel shown on get_time
//   get_time   out  [24] BCD time of channel sel, 0 if sel >= CHANNELS
//   running    out  [CHANNELS] 1 while channel in RUN
//   expired    out  [CHANNELS] 1 while channel in EXPIRED
//   complete   out  [CHANNELS] 1-cycle pulse on reaching 00:00:00
//   load_err   out  1-cycle pulse after any invalid load strobe
module nap_countdown_bank
  import nap_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned TICK_DIV   = 1_000_000,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned MAX_HOUR   = 23
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] load,
  input  logic [23:0]         load_time,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] pause,
  input  logic [CHANNELS-1:0] clear,
  input  logic [CHANNELS-1:0] snooze,
  input  logic [SEL_W-1:0]    sel,
  output logic [23:0]         get_time,
  output logic [CHANNELS-1:0] running,
  output logic [CHANNELS-1:0] expired,
  output logic [CHANNELS-1:0] complete,
  output logic                load_err
);

  localparam int unsigned PS_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0]     ps_cnt;
  logic                tick;
  bcd_time_t           ch_time [CHANNELS];
  logic [CHANNELS-1:0] ch_load_err;

  // Free-running prescaler; start never re-phases it, so a fresh run may see
  // its first tick anywhere from 1 to TICK_DIV cycles later.
  always_ff @(posedge clock) begin
    if (!reset)                ps_cnt <= '0;
    else if (ps_cnt == PS_LAST) ps_cnt <= '0;
    else                       ps_cnt <= ps_cnt + PS_W'(1);
  end

  assign tick = (ps_cnt == PS_LAST);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    nap_countdown_channel #(
      .SNOOZE_MIN (SNOOZE_MIN),
      .MAX_SNOOZE (MAX_SNOOZE),
      .MAX_HOUR   (MAX_HOUR)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .tick      (tick),
      .load      (load[g]),
      .load_time (bcd_time_t'(load_time)),
      .start     (start[g]),
      .pause     (pause[g]),
      .clear     (clear[g]),
      .snooze    (snooze[g]),
      .cur_time  (ch_time[g]),
      .running   (running[g]),
      .expired   (expired[g]),
      .complete  (complete[g]),
      .load_err  (ch_load_err[g])
    );
  end

  assign load_err = |ch_load_err;

  // Display select over registered channel times; sel is a slow panel control.
  always_comb begin
    // NOTE: default first so an out-of-range sel cannot infer a latch.
    get_time = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(sel) == i) get_time = ch_time[i];
    end
  end

endmodule

// File: tb/tb_nap_countdown_bank.sv
// Directed self-checking bench for nap_countdown_bank
// (CHANNELS=4, TICK_DIV=4, SNOOZE_MIN=5, MAX_SNOOZE=1, MAX_HOUR=23).
module tb_nap_countdown_bank;

  localparam int TICK_DIV = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  load, start, pause, clear, snooze;
  logic [23:0] load_time;
  logic [1:0]  sel;
  logic [23:0] get_time;
  logic [3:0]  running, expired, complete;
  logic        load_err;

  int n_vec = 0;
  int n_err = 0;
  int pcnt  = 0;
  bit tick_seen;
  int got;

  always #5 clock = ~clock;

  nap_countdown_bank #(
    .CHANNELS   (4),
    .SEL_W      (2),
    .TICK_DIV   (TICK_DIV),
    .SNOOZE_MIN (5),
    .MAX_SNOOZE (1),
    .MAX_HOUR   (23)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_time (load_time),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .snooze    (snooze),
    .sel       (sel),
    .get_time  (get_time),
    .running   (running),
    .expired   (expired),
    .complete  (complete),
    .load_err  (load_err)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // One clock edge; tracks the prescaler phase so tick-aligned waits are known.
  task automatic step();
    @(posedge clock);
    tick_seen = reset && (pcnt == TICK_DIV - 1);
    if (!reset) pcnt = 0;
    else        pcnt = (pcnt == TICK_DIV - 1) ? 0 : pcnt + 1;
    #1;
  endtask

  task automatic cmd(input logic [3:0] ld, input logic [3:0] st, input logic [3:0] ps,
                     input logic [3:0] cl, input logic [3:0] sz, input logic [23:0] t);
    load = ld; start = st; pause = ps; clear = cl; snooze = sz; load_time = t;
    step();
    load = '0; start = '0; pause = '0; clear = '0; snooze = '0; load_time = '0;
  endtask

  // Advance until n prescaler ticks have hit the channels.
  task automatic run_ticks(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n * TICK_DIV + 8 && seen < n; i++) begin
      step();
      if (tick_seen) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    load = '0; start = '0; pause = '0; clear = '0; snooze = '0; load_time = '0;
    sel = 2'd0;
    repeat (3) step();
    check("rst_running",  32'(running),  32'h0);
    check("rst_expired",  32'(expired),  32'h0);
    check("rst_complete", 32'(complete), 32'h0);
    check("rst_load_err", 32'(load_err), 32'h0);
    check("rst_time",     32'(get_time), 32'h0);
    reset = 1'b1;

    // ch0: 00:00:03 counts down to expiry on the third tick after start.
    cmd(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h000003);
    check("ch0_load_time", 32'(get_time), 32'h000003);
    check("ch0_load_idle", 32'(running[0]), 32'h0);
    cmd(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 24'h0);
    check("ch0_start_run", 32'(running[0]), 32'h1);
    got = 0;
    for (int i = 0; i < 20 && got < 3; i++) begin
      step();
      if (tick_seen) begin
        got++;
        if (got == 1) check("ch0_tick1_time", 32'(get_time), 32'h000002);
        if (got < 3)  check("ch0_no_early_complete", 32'(complete[0]), 32'h0);
      end
    end
    check("ch0_complete",  32'(complete[0]), 32'h1);
    check("ch0_expired",   32'(expired[0]),  32'h1);
    check("ch0_stopped",   32'(running[0]),  32'h0);
    check("ch0_zero_time", 32'(get_time),    32'h0);
    step();
    check("ch0_complete_pulse", 32'(complete[0]), 32'h0);
    check("ch0_expired_level",  32'(expired[0]),  32'h1);

    // ch1: hour and ten-hour borrows.
    sel = 2'd1;
    cmd(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h010000);
    cmd(4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 24'h0);
    run_ticks(1, got);
    check("ch1_borrow_hour", 32'(get_time), 32'h005959);
    cmd(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h100000);
    check("ch1_reload_time", 32'(get_time),   32'h100000);
    check("ch1_reload_idle", 32'(running[1]), 32'h0);
    cmd(4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 24'h0);
    run_ticks(1, got);
    check("ch1_borrow_h10", 32'(get_time), 32'h095959);

    // ch2: invalid loads are rejected with a one-cycle load_err pulse.
    sel = 2'd2;
    cmd(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h000010);
    check("ch2_valid_load", 32'(get_time), 32'h000010);
    cmd(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h006000);
    check("ch2_m10_err",      32'(load_err), 32'h1);
    check("ch2_m10_kept",     32'(get_time), 32'h000010);
    step();
    check("ch2_err_pulse",    32'(load_err), 32'h0);
    cmd(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h240000);
    check("ch2_hour_err",     32'(load_err),   32'h1);
    check("ch2_hour_kept",    32'(get_time),   32'h000010);
    check("ch2_hour_idle",    32'(running[2]), 32'h0);
    cmd(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h00000a);
    check("ch2_digit_err",    32'(load_err), 32'h1);
    cmd(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h235959);
    check("ch2_max_ok",       32'(load_err), 32'h0);
    check("ch2_max_time",     32'(get_time), 32'h235959);
    cmd(4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 24'h0);
    check("ch2_clear",        32'(get_time), 32'h0);

    // ch0: one snooze allowed, the second is ignored.
    sel = 2'd0;
    cmd(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 24'h0);
    check("snz_time",    32'(get_time),   32'h000500);
    check("snz_run",     32'(running[0]), 32'h1);
    check("snz_unexp",   32'(expired[0]), 32'h0);
    run_ticks(1, got);
    check("snz_tick1",   32'(get_time),   32'h000459);
    run_ticks(298, got);
    check("snz_last_s",  32'(get_time),   32'h000001);
    run_ticks(1, got);
    check("snz_complete", 32'(complete[0]), 32'h1);
    check("snz_expired",  32'(expired[0]),  32'h1);
    cmd(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 24'h0);
    check("snz2_ignored_exp", 32'(expired[0]), 32'h1);
    check("snz2_ignored_run", 32'(running[0]), 32'h0);
    check("snz2_ignored_t",   32'(get_time),   32'h0);

    // ch3: clear beats load and tick on the same edge; start at zero is ignored.
    sel = 2'd3;
    cmd(4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h000005);
    cmd(4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 24'h0);
    check("ch3_run", 32'(running[3]), 32'h1);
    for (int i = 0; i < 8 && pcnt != TICK_DIV - 1; i++) step();
    cmd(4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 24'h123456);
    check("ch3_clr_tick_seen", 32'(tick_seen), 32'h1);
    check("ch3_clr_time",      32'(get_time),   32'h0);
    check("ch3_clr_idle",      32'(running[3]), 32'h0);
    cmd(4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 24'h0);
    check("ch3_start_zero",    32'(running[3]), 32'h0);

    // Pause / resume on ch2.
    sel = 2'd2;
    cmd(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h000100);
    cmd(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 24'h0);
    cmd(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 24'h0);
    check("ch2_paused", 32'(running[2]), 32'h0);
    run_ticks(2, got);
    check("ch2_pause_holds", 32'(get_time), 32'h000100);
    cmd(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 24'h0);
    check("ch2_resumed", 32'(running[2]), 32'h1);
    run_ticks(1, got);
    check("ch2_resume_dec", 32'(get_time), 32'h000059);

    // Reset mid-run clears everything and re-phases the prescaler.
    sel = 2'd1;
    reset = 1'b0;
    step();
    check("mid_rst_running",  32'(running),  32'h0);
    check("mid_rst_expired",  32'(expired),  32'h0);
    check("mid_rst_complete", 32'(complete), 32'h0);
    check("mid_rst_load_err", 32'(load_err), 32'h0);
    check("mid_rst_time",     32'(get_time), 32'h0);
    reset = 1'b1;
    sel = 2'd0;
    cmd(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 24'h000002);
    cmd(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 24'h0);
    step();
    check("ps_restart_hold", 32'(get_time), 32'h000002);
    step();
    check("ps_restart_tick", 32'(get_time), 32'h000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
